// File: rtl/uart_tx_peripheral_if.sv
// Peripheral-memory side of the UART transmitter: request bytes in, serial line and status out.
interface uart_tx_peripheral_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0]                  tx_data;
  logic [7:0]                  tx_seq;
  logic                        tx;
  logic [7:0]                  ack_seq;
  logic [7:0]                  status;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (output tx_data, tx_seq, input tx, ack_seq, status, fifo_count);
  modport slave  (input tx_data, tx_seq, output tx, ack_seq, status, fifo_count);
endinterface

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: sequence-byte changes queue data bytes into a small FIFO,
// which a four-state FSM serialises back-to-back.
module uart_tx_peripheral #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_peripheral_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud, baud_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        shift_p0, shift_next;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic [7:0]        last_seq, ack_seq;
  logic              overflow, tx_p0, busy_p0, full_p0;
  logic              req, push, pop, baud_end, tx_next;

  // Fullness is judged on the pre-edge count, so a same-edge pop never frees a slot.
  assign req        = (bus.tx_seq != last_seq);
  assign push       = req && (count != CNT_W'(FIFO_DEPTH));
  assign baud_end   = (baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shift_p0;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr];
          baud_next  = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_p0[7:1]};
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 1'b1;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (count != '0) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr];
            bit_next   = '0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      last_seq <= bus.tx_seq;
      ack_seq  <= bus.tx_seq;
      tx_p0    <= 1'b1;
      busy_p0  <= 1'b0;
      full_p0  <= 1'b0;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      count   <= count_next;
      if (push)        wr_ptr   <= wr_ptr + 1'b1;
      if (pop)         rd_ptr   <= rd_ptr + 1'b1;
      if (req)         last_seq <= bus.tx_seq;
      if (push)        ack_seq  <= bus.tx_seq;
      if (req && !push) overflow <= 1'b1;
      tx_p0   <= tx_next;
      busy_p0 <= (state_next != IDLE) || (count_next != '0);
      full_p0 <= (count_next == CNT_W'(FIFO_DEPTH));
    end
  end

  // Datapath storage carries no reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    shift_p0 <= shift_next;
    if (push) fifo_mem[wr_ptr] <= bus.tx_data;
  end

  assign bus.tx         = tx_p0;
  assign bus.ack_seq    = ack_seq;
  assign bus.status     = {5'b0, overflow, full_p0, busy_p0};
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Directed bench for uart_tx_peripheral with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_peripheral;
  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  uart_tx_peripheral_if #(.FIFO_DEPTH(4)) bus ();

  uart_tx_peripheral #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks tx over frame cycles c_from..c_to (cycle 0 = first start-bit cycle), stepping after each.
  task automatic frame(input logic [7:0] b, input int c_from, input int c_to);
    logic [7:0] exp;
    for (int c = c_from; c <= c_to; c++) begin
      if (c < CPB)            exp = 8'h00;
      else if (c < 9 * CPB)   exp = {7'b0, b[(c - CPB) / CPB]};
      else                    exp = 8'h01;
      check($sformatf("tx_frame_%02h_c%0d", b, c), {7'b0, bus.tx}, exp);
      step();
    end
  endtask

  task automatic quiet(input string tag, input int n);
    logic low = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (bus.tx !== 1'b1) low = 1'b1;
      step();
    end
    check(tag, {7'b0, low}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    bus.tx_data = 8'h00;
    bus.tx_seq  = 8'h37;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_ack",    bus.ack_seq, 8'h37);
    check("rst_status", bus.status, 8'h00);
    check("rst_tx",     {7'b0, bus.tx}, 8'h01);
    check("rst_count",  {5'b0, bus.fifo_count}, 8'h00);
    quiet("rst_quiet", 100);

    // Single byte
    bus.tx_data = 8'hA5;
    bus.tx_seq  = 8'h38;
    step();
    check("single_ack",    bus.ack_seq, 8'h38);
    check("single_count",  {5'b0, bus.fifo_count}, 8'h01);
    check("single_busy",   bus.status, 8'h01);
    step();
    check("single_popped", {5'b0, bus.fifo_count}, 8'h00);
    frame(8'hA5, 0, 10 * CPB - 1);
    check("single_idle",   bus.status, 8'h00);

    // Burst of six, sixth dropped
    for (int i = 0; i < 6; i++) begin
      bus.tx_data = 8'(i + 1);
      bus.tx_seq  = 8'(8'h39 + i);
      step();
    end
    check("burst_ack",    bus.ack_seq, 8'h3D);
    check("burst_status", bus.status, 8'h07);
    check("burst_count",  {5'b0, bus.fifo_count}, 8'h04);
    frame(8'h01, 4, 10 * CPB - 1);
    for (int i = 2; i <= 5; i++) frame(8'(i), 0, 10 * CPB - 1);
    check("burst_end_status", bus.status, 8'h04);
    check("burst_end_count",  {5'b0, bus.fifo_count}, 8'h00);

    // Sequence wrap 0xFF -> 0x00
    bus.tx_data = 8'h11;
    bus.tx_seq  = 8'hFF;
    step();
    step();
    frame(8'h11, 0, 10 * CPB - 1);
    bus.tx_data = 8'hC3;
    bus.tx_seq  = 8'h00;
    step();
    check("wrap_ack",   bus.ack_seq, 8'h00);
    check("wrap_count", {5'b0, bus.fifo_count}, 8'h01);
    step();
    frame(8'hC3, 0, 10 * CPB - 1);
    check("wrap_status", bus.status, 8'h04);
    quiet("wrap_quiet", 20);

    // Reset during data bit 3 with one byte still queued
    bus.tx_data = 8'hA5;
    bus.tx_seq  = 8'h01;
    step();
    bus.tx_data = 8'h77;
    bus.tx_seq  = 8'h02;
    step();
    frame(8'hA5, 0, 17);
    check("mid_bit3",  {7'b0, bus.tx}, 8'h00);
    check("mid_count", {5'b0, bus.fifo_count}, 8'h01);
    reset = 1'b1;
    step();
    check("mid_rst_tx",     {7'b0, bus.tx}, 8'h01);
    check("mid_rst_count",  {5'b0, bus.fifo_count}, 8'h00);
    check("mid_rst_status", bus.status, 8'h00);
    check("mid_rst_ack",    bus.ack_seq, 8'h02);
    reset = 1'b0;
    quiet("mid_quiet", 60);

    // Push aligned with the stop-end pop while two bytes are queued
    bus.tx_data = 8'h10;
    bus.tx_seq  = 8'h03;
    step();
    bus.tx_data = 8'h20;
    bus.tx_seq  = 8'h04;
    step();
    bus.tx_data = 8'h30;
    bus.tx_seq  = 8'h05;
    step();
    check("pp_count_before", {5'b0, bus.fifo_count}, 8'h02);
    frame(8'h10, 1, 10 * CPB - 2);
    bus.tx_data = 8'h40;
    bus.tx_seq  = 8'h06;
    check("pp_stop", {7'b0, bus.tx}, 8'h01);
    step();
    check("pp_count_after", {5'b0, bus.fifo_count}, 8'h02);
    check("pp_ack",         bus.ack_seq, 8'h06);
    frame(8'h20, 0, 10 * CPB - 1);
    frame(8'h30, 0, 10 * CPB - 1);
    frame(8'h40, 0, 10 * CPB - 1);
    check("pp_end_status", bus.status, 8'h00);
    check("pp_end_count",  {5'b0, bus.fifo_count}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
